note_voice_scheduler: RTL and testbench

Time-shares one external combinational 64x16 note-divider ROM among NUM_VOICES voices. Each voice holds a 6-bit note index and runs a square-wave tone generator clocked at 50 kHz. A round-robin FSM fetches the half-period divider from the ROM whenever a voice's note changes. The block sits between the loop/keyboard note sources and the audio mixer/DAC path.

---
 rtl/note_voice_scheduler_pkg.sv | 19 +
 rtl/note_voice_scheduler_tone_gen.sv | 58 +++++
 rtl/note_voice_scheduler.sv | 159 +++++++++++++++
 tb/tb_note_voice_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/note_voice_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// note_sched_pkg : shared constants and FSM state type for note_voice_scheduler
// Revision: 1.0
// ============================================================================
package note_sched_pkg;

    localparam int          c_idx_w    = 6;
    localparam int          c_div_w    = 16;
    localparam logic [15:0] SILENT_DIV = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/note_voice_scheduler_tone_gen.sv
`default_nettype none
// ============================================================================
// note_tone_gen : one voice's divider register, half-period counter and TONE bit
// Optional macro NOTE_SCHED_MUTE_EN adds i_mute output gating.
// Revision: 1.0
// ============================================================================
module note_tone_gen
    import note_sched_pkg::*;
#(
    parameter int DIV_W = c_div_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_div,
    input  logic             i_clear,
`ifdef NOTE_SCHED_MUTE_EN
    input  logic             i_mute,
`endif
    output logic             o_tone
);

    localparam logic [DIV_W-1:0] c_silent = DIV_W'(SILENT_DIV);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_tone;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= c_silent;
            r_cnt  <= '0;
            r_tone <= 1'b0;
        end else begin
            if (i_load) begin
                r_div <= i_load_div;
            end
            // A fresh load restarts the phase from zero with the tone low
            if (i_clear || (r_div == c_silent)) begin
                r_cnt  <= '0;
                r_tone <= 1'b0;
            end else if (r_cnt == r_div) begin
                r_cnt  <= '0;
                r_tone <= ~r_tone;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef NOTE_SCHED_MUTE_EN
    assign o_tone = r_tone & ~i_mute;
`else
    assign o_tone = r_tone;
`endif

endmodule
`default_nettype wire

// File: rtl/note_voice_scheduler.sv
`default_nettype none
// ============================================================================
// note_voice_scheduler : round-robin sharing of one note-divider ROM among voices
// Optional macro NOTE_SCHED_MUTE_EN adds the per-voice MUTE input.
// Revision: 1.0
// ============================================================================
module note_voice_scheduler
    import note_sched_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = c_idx_w,
    parameter int DIV_W      = c_div_w
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              NOTE_WE,
    input  logic [$clog2(NUM_VOICES)-1:0]     NOTE_SEL,
    input  logic [IDX_W-1:0]                  NOTE_IDX,
    output logic                              NOTE_BUSY,
    output logic [IDX_W-1:0]                  ROM_I,
    input  logic [DIV_W-1:0]                  ROM_DOUT,
`ifdef NOTE_SCHED_MUTE_EN
    input  logic [NUM_VOICES-1:0]             MUTE,
`endif
    output logic [NUM_VOICES-1:0]             TONE,
    output logic [$clog2(NUM_VOICES+1)-1:0]   MIX
);

    localparam int SEL_W = $clog2(NUM_VOICES);
    localparam int MIX_W = $clog2(NUM_VOICES + 1);

    sched_state_t r_state, w_state_nxt;

    logic [IDX_W-1:0]      r_idx [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_pend, w_pend_nxt;
    logic [SEL_W-1:0]      r_cur, r_rr, w_pick, w_cur_inc;
    logic                  r_stale;
    logic [MIX_W-1:0]      r_mix, w_pop;
    logic                  w_found, w_pick_en, w_load, w_we_ok, w_we_cur;
    logic [SEL_W:0]        w_scan;

    assign w_we_ok   = NOTE_WE && ({1'b0, NOTE_SEL} < (SEL_W + 1)'(NUM_VOICES));
    assign w_we_cur  = w_we_ok && (NOTE_SEL == r_cur);
    assign w_cur_inc = (r_cur == SEL_W'(NUM_VOICES - 1)) ? '0 : r_cur + 1'b1;

    // First pending voice at or after the round-robin pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = '0;
        for (int k = NUM_VOICES - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_rr} + (SEL_W + 1)'(k);
            if (w_scan >= (SEL_W + 1)'(NUM_VOICES)) begin
                w_scan = w_scan - (SEL_W + 1)'(NUM_VOICES);
            end
            if (r_pend[w_scan[SEL_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_scan[SEL_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pick_en   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_pick_en   = 1'b1;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: w_state_nxt = LOAD;
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_stale marks an in-flight voice rewritten after its address was issued
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_load && !r_stale) begin
            w_pend_nxt[r_cur] = 1'b0;
        end
        if (w_we_ok) begin
            w_pend_nxt[NOTE_SEL] = 1'b1;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_pop = w_pop + MIX_W'(TONE[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_idx[i] <= '0;
            end
            r_pend  <= '0;
            r_cur   <= '0;
            r_rr    <= '0;
            r_stale <= 1'b0;
            r_mix   <= '0;
            ROM_I   <= '0;
        end else begin
            if (w_we_ok) begin
                r_idx[NOTE_SEL] <= NOTE_IDX;
            end
            r_pend <= w_pend_nxt;
            if (w_pick_en) begin
                ROM_I   <= r_idx[w_pick];
                r_cur   <= w_pick;
                r_stale <= w_we_ok && (NOTE_SEL == w_pick);
            end else if ((r_state == FETCH) && w_we_cur) begin
                r_stale <= 1'b1;
            end
            if (w_load) begin
                r_rr <= w_cur_inc;
            end
            r_mix <= w_pop;
        end
    end

    assign NOTE_BUSY = (|r_pend) || (r_state != IDLE);
    assign MIX       = r_mix;

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        note_tone_gen #(
            .DIV_W (DIV_W)
        ) u_tone (
            .clk        (CLK),
            .rst        (RST),
            .i_load     (w_load && (r_cur == SEL_W'(gi))),
            .i_load_div (ROM_DOUT),
            .i_clear    (w_load && (r_cur == SEL_W'(gi))),
`ifdef NOTE_SCHED_MUTE_EN
            .i_mute     (MUTE[gi]),
`endif
            .o_tone     (TONE[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_note_voice_scheduler.sv
`default_nettype none
// ============================================================================
// tb_note_voice_scheduler : directed + random stimulus against a behavioural model
// Revision: 1.0
// ============================================================================
module tb_note_voice_scheduler;

    localparam int NV = 4;

    logic       CLK;
    logic       RST;
    logic       NOTE_WE;
    logic [1:0] NOTE_SEL;
    logic [5:0] NOTE_IDX;
    logic       NOTE_BUSY;
    logic [5:0] ROM_I;
    logic [15:0] ROM_DOUT;
    logic [3:0] TONE;
    logic [2:0] MIX;
    logic [3:0] mute_v;

    int n_total;
    int n_bad;

    function automatic logic [15:0] rom_fn(input logic [5:0] a);
        case (a)
            6'h00:   return 16'hFFFF;
            6'h2E:   return 16'h0039;
            6'h25:   return 16'h0060;
            default: return 16'((int'(a) * 3) % 50);
        endcase
    endfunction

    assign ROM_DOUT = rom_fn(ROM_I);

    note_voice_scheduler #(
        .NUM_VOICES (NV),
        .IDX_W      (6),
        .DIV_W      (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .NOTE_WE   (NOTE_WE),
        .NOTE_SEL  (NOTE_SEL),
        .NOTE_IDX  (NOTE_IDX),
        .NOTE_BUSY (NOTE_BUSY),
        .ROM_I     (ROM_I),
        .ROM_DOUT  (ROM_DOUT),
`ifdef NOTE_SCHED_MUTE_EN
        .MUTE      (mute_v),
`endif
        .TONE      (TONE),
        .MIX       (MIX)
    );

    initial begin
        CLK = 1'b1;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: notes, pending set, one in-flight fetch job, square waves
    logic [5:0] m_idx [NV];
    logic [3:0] m_pend;
    int         m_div [NV];
    int         m_cnt [NV];
    logic [3:0] m_tone;
    int         m_mix;
    logic [5:0] m_rom;
    int         m_left;
    int         m_v;
    int         m_rr;
    bit         m_refetch;

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_idx[i] = '0;
            m_div[i] = 16'hFFFF;
            m_cnt[i] = 0;
        end
        m_pend = '0; m_tone = '0; m_mix = 0; m_rom = '0;
        m_left = 0; m_v = 0; m_rr = 0; m_refetch = 0;
    endtask

    task automatic model_step(input bit we, input int sel, input logic [5:0] idx, input bit rst);
        if (rst) begin
            model_reset();
            return;
        end
        m_mix = $countones(m_tone & ~mute_v);
        for (int i = 0; i < NV; i++) begin
            if (m_div[i] == 16'hFFFF) begin
                m_cnt[i] = 0; m_tone[i] = 1'b0;
            end else if (m_cnt[i] == m_div[i]) begin
                m_cnt[i] = 0; m_tone[i] = ~m_tone[i];
            end else begin
                m_cnt[i]++;
            end
        end
        if (m_left == 1) begin
            m_div[m_v] = int'(rom_fn(m_rom));
            m_cnt[m_v] = 0;
            m_tone[m_v] = 1'b0;
            if (!m_refetch) m_pend[m_v] = 1'b0;
            m_rr = (m_v + 1) % NV;
            m_left = 0;
        end else if (m_left == 2) begin
            if (we && sel == m_v) m_refetch = 1;
            m_left = 1;
        end else if (m_pend != 0) begin
            for (int k = 0; k < NV; k++) begin
                int v;
                v = (m_rr + k) % NV;
                if (m_pend[v]) begin
                    m_v = v;
                    break;
                end
            end
            m_rom = m_idx[m_v];
            m_refetch = we && (sel == m_v);
            m_left = 2;
        end
        if (we) begin
            m_idx[sel] = idx;
            m_pend[sel] = 1'b1;
        end
    endtask

    task automatic tick(input bit we, input int sel, input logic [5:0] idx, input bit rst);
        NOTE_WE = we; NOTE_SEL = 2'(sel); NOTE_IDX = idx; RST = rst;
        @(negedge CLK);
        check_eq("tone", 32'(TONE), 32'(m_tone & ~mute_v));
        check_eq("mix", 32'(MIX), 32'(m_mix));
        check_eq("busy", 32'(NOTE_BUSY), 32'((m_pend != 0) || (m_left != 0)));
        check_eq("rom_i", 32'(ROM_I), 32'(m_rom));
        @(posedge CLK);
        model_step(we, sel, idx, rst);
        #1;
    endtask

    initial begin
        int rise, fall, busy_n;
        n_total = 0; n_bad = 0;
        mute_v = '0;
        NOTE_WE = 0; NOTE_SEL = '0; NOTE_IDX = '0; RST = 1;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;

        // Quiet after reset
        repeat (100) tick(0, 0, 6'h0, 0);
        check_eq("rst_quiet_tone", 32'(TONE), 32'h0);
        check_eq("rst_quiet_romi", 32'(ROM_I), 32'h0);

        // Voice 0, divider 0x39: half-period 58 cycles, busy for 3 cycles
        rise = -1; fall = -1; busy_n = 0;
        for (int j = 0; j < 200; j++) begin
            if (j == 0) tick(1, 0, 6'h2E, 0);
            else        tick(0, 0, 6'h0, 0);
            if (NOTE_BUSY) busy_n++;
            if (TONE[0] && rise < 0) rise = j + 1;
            if (rise >= 0 && !TONE[0] && fall < 0) fall = j + 1;
        end
        check_eq("v0_busy_cycles", 32'(busy_n), 32'd3);
        check_eq("v0_first_rise", 32'(rise), 32'd62);
        check_eq("v0_half_period", 32'(fall - rise), 32'd58);

        // Voice 2 playing, then silenced by a divider of 0xFFFF
        tick(1, 2, 6'h05, 0);
        repeat (60) tick(0, 0, 6'h0, 0);
        tick(1, 2, 6'h00, 0);
        repeat (80) tick(0, 0, 6'h0, 0);
        check_eq("v2_silent", 32'(TONE[2]), 32'h0);

        // Back-to-back writes to voices 1..3
        tick(1, 1, 6'h0A, 0);
        tick(1, 2, 6'h0B, 0);
        tick(1, 3, 6'h0C, 0);
        repeat (20) tick(0, 0, 6'h0, 0);

        // Rewrite voice 1 exactly in its LOAD cycle
        tick(1, 1, 6'h07, 0);
        tick(0, 0, 6'h0, 0);
        tick(0, 0, 6'h0, 0);
        tick(1, 1, 6'h25, 0);
        check_eq("refetch_busy", 32'(NOTE_BUSY), 32'h1);
        repeat (300) tick(0, 0, 6'h0, 0);

        // Reset in the middle of a fetch
        tick(1, 3, 6'h09, 0);
        tick(0, 0, 6'h0, 0);
        tick(0, 0, 6'h0, 1);
        check_eq("midrst_busy", 32'(NOTE_BUSY), 32'h0);
        check_eq("midrst_tone", 32'(TONE), 32'h0);
        check_eq("midrst_romi", 32'(ROM_I), 32'h0);
        repeat (20) tick(0, 0, 6'h0, 0);
        check_eq("midrst_noload", 32'(TONE), 32'h0);

`ifdef NOTE_SCHED_MUTE_EN
        for (int v = 0; v < NV; v++) tick(1, v, 6'(v + 3), 0);
        repeat (40) tick(0, 0, 6'h0, 0);
        mute_v = 4'b0001;
        repeat (100) tick(0, 0, 6'h0, 0);
        check_eq("mute_t0", 32'(TONE[0]), 32'h0);
        mute_v = '0;
`endif

        // Random traffic including div=0 notes and occasional resets
        for (int j = 0; j < 3000; j++) begin
`ifdef NOTE_SCHED_MUTE_EN
            if ($urandom_range(0, 49) == 0) mute_v = 4'($urandom_range(0, 15));
`endif
            tick(($urandom_range(0, 3) == 0), int'($urandom_range(0, NV - 1)),
                 6'($urandom_range(0, 63)), ($urandom_range(0, 399) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
